// File: rtl/tart_bank_readout_pkg.sv
// -----------------------------------------------------------------------------
// tart_bank_readout_pkg
// Shared definitions for the TART visibility-bank readout slice.
//   - state_t        : readout FSM states (IDLE / READ / DRAIN)
//   - DEF_WIDTH/WORDS: default accumulator word width and words per bank
//   - HDR_*_W        : field widths of the optional frame header word
//   - makeHeader()   : packs {frame_count, bank} into a header word
// Optional feature: TART_READOUT_HEADER_EN (frame header word), used by
// tart_bank_readout.
// -----------------------------------------------------------------------------
package tart_bank_readout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DEF_WIDTH  = 24;
    localparam int DEF_WORDS  = 576;

    // The header carries an 8-bit frame counter above an 8-bit bank field,
    // so bank 1 of frame 1 reads as 0x0101 regardless of BBITS.
    localparam int HDR_CNT_W  = 8;
    localparam int HDR_BANK_W = 8;

    function automatic logic [HDR_CNT_W+HDR_BANK_W-1:0] makeHeader(
        input logic [HDR_CNT_W-1:0]  cnt,
        input logic [HDR_BANK_W-1:0] bank
    );
        return {cnt, bank};
    endfunction

endpackage

// File: rtl/tart_bank_readout_skid.sv
// -----------------------------------------------------------------------------
// tart_bank_readout_skid
// Two-entry valid/ready skid buffer with registered outputs. It carries
// {sof, eof, dat} words from the RAM read pipeline to the bus interface and
// exposes its occupancy so the parent can throttle reads and never drop a word.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (flushes contents)
//   i_push       : a word is presented on i_data this cycle
//   i_data       : word to store
//   i_ready      : downstream ready; a word leaves when o_valid && i_ready
//   o_valid      : head entry valid
//   o_data       : head entry (held stable while stalled)
//   o_count      : number of stored entries (0..2)
// -----------------------------------------------------------------------------
module tart_bank_readout_skid
    import tart_bank_readout_pkg::*;
#(
    parameter int W = DEF_WIDTH + 2
)(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_rdPtr;
    logic         r_wrPtr;
    logic [1:0]   r_count;
    logic         w_pop;
    logic         w_push;

    assign w_pop   = i_ready && (r_count != 2'd0);
    // A push into a full buffer is only accepted when the head leaves in the
    // same cycle; the parent's read credit keeps this from ever being needed.
    assign w_push  = i_push && ((r_count != 2'd2) || w_pop);

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rdPtr];
    assign o_count = r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rdPtr  <= 1'b0;
            r_wrPtr  <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= i_data;
                r_wrPtr        <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/tart_bank_readout.sv
// -----------------------------------------------------------------------------
// tart_bank_readout
// Bus-domain consumer of the correlator bank-swap pulse. Each swap makes the
// just-filled bank readable; the bank is then streamed out of the accumulator
// RAM as a valid/ready word stream. One further bank can wait as pending;
// a third discards the older pending bank and raises a sticky overflow flag.
// Ports:
//   clk_i, rst_i   : bus clock, synchronous active-high reset
//   swap_i         : 1-cycle bank-swap pulse
//   clear_i        : clears overflow_o (a new overflow wins)
//   ram_rd_o       : RAM read strobe
//   ram_addr_o     : {bank, word} read address
//   ram_dat_i      : RAM data, valid one cycle after ram_rd_o
//   stb_o, rdy_i   : output valid / downstream ready
//   dat_o          : output word
//   sof_o, eof_o   : first / last word of a frame
//   bank_o         : bank currently being read
//   busy_o         : FSM not idle
//   overflow_o     : sticky, a readable bank was discarded
// Optional feature: TART_READOUT_HEADER_EN prefixes each frame with the word
// {frame_count[7:0], bank[7:0]} (zero-extended); sof_o then marks the header.
// -----------------------------------------------------------------------------
module tart_bank_readout
    import tart_bank_readout_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WORDS = DEF_WORDS,
    parameter int ABITS = 10,
    parameter int BBITS = 4
)(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   swap_i,
    input  logic                   clear_i,
    output logic                   ram_rd_o,
    output logic [BBITS+ABITS-1:0] ram_addr_o,
    input  logic [WIDTH-1:0]       ram_dat_i,
    output logic                   stb_o,
    input  logic                   rdy_i,
    output logic [WIDTH-1:0]       dat_o,
    output logic                   sof_o,
    output logic                   eof_o,
    output logic [BBITS-1:0]       bank_o,
    output logic                   busy_o,
    output logic                   overflow_o
);

    // A frame is a run of "slots"; with the header enabled slot 0 is the
    // header and slots 1..WORDS map to RAM words 0..WORDS-1.
`ifdef TART_READOUT_HEADER_EN
    localparam int SLOTS = WORDS + 1;
`else
    localparam int SLOTS = WORDS;
`endif
    localparam int               SBITS     = ABITS + 1;
    localparam logic [SBITS-1:0] LAST_SLOT = SBITS'(SLOTS - 1);
    localparam int               SKW       = WIDTH + 2;

    state_t             r_state;
    state_t             w_nextState;
    logic [BBITS-1:0]   r_wrBank;
    logic [BBITS-1:0]   r_rdBank;
    logic [BBITS-1:0]   r_pendBank;
    logic [BBITS-1:0]   w_startBank;
    logic               r_pending;
    logic               r_overflow;
    logic [SBITS-1:0]   r_slot;
    logic               r_inflight;
    logic               r_infSof;
    logic               r_infEof;

    logic               w_start;
    logic               w_takePend;
    logic               w_swapToPend;
    logic               w_busy;
    logic               w_xfer;
    logic               w_credit;
    logic               w_issue;
    logic               w_lastSlot;
    logic               w_hdrSlot;
    logic [ABITS-1:0]   w_word;
    logic [WIDTH-1:0]   w_pushDat;
    logic [1:0]         w_skidCount;
    logic [1:0]         w_skidLevel;
    logic               w_skidValid;
    logic [SKW-1:0]     w_skidOut;

    assign w_busy = (r_state != ST_IDLE);
    assign w_xfer = w_skidValid && rdy_i;

    // Read credit: the skid level after this cycle's transfer plus the read
    // already in flight must leave room for one more word. Counting the
    // departing word lets reads run back-to-back while rdy_i stays high.
    assign w_skidLevel = w_skidCount - {1'b0, w_xfer};
    assign w_credit    = ({1'b0, w_skidLevel} + {2'b00, r_inflight}) < 3'd2;
    assign w_issue     = (r_state == ST_READ) && w_credit;
    assign w_lastSlot  = (r_slot == LAST_SLOT);

`ifdef TART_READOUT_HEADER_EN
    logic                 r_infHdr;
    logic [WIDTH-1:0]     r_hdrWord;
    logic [HDR_CNT_W-1:0] r_frameCnt;

    assign w_hdrSlot = (r_slot == '0);
    assign w_word    = w_hdrSlot ? '0 : ABITS'(r_slot - SBITS'(1));
    assign w_pushDat = r_infHdr ? r_hdrWord : ram_dat_i;

    // The header slot issues no RAM read; its word is built here and
    // travels down the same one-cycle pipeline as a RAM word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_infHdr   <= 1'b0;
            r_hdrWord  <= '0;
            r_frameCnt <= '0;
        end else begin
            r_infHdr <= w_issue && w_hdrSlot;
            if (w_issue && w_hdrSlot) begin
                r_hdrWord  <= WIDTH'(makeHeader(r_frameCnt, HDR_BANK_W'(r_rdBank)));
                r_frameCnt <= r_frameCnt + HDR_CNT_W'(1);
            end
        end
    end
`else
    assign w_hdrSlot = 1'b0;
    assign w_word    = ABITS'(r_slot);
    assign w_pushDat = ram_dat_i;
`endif

    assign ram_rd_o   = w_issue && !w_hdrSlot;
    assign ram_addr_o = {r_rdBank, w_word};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A pending bank is started straight from READ (on the last issue) or
    // DRAIN, so back-to-back frames stream without a bubble. A pending flag
    // seen in IDLE comes from a swap in the cycle that returned to IDLE.
    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_takePend  = 1'b0;
        w_startBank = r_rdBank;
        case (r_state)
            ST_IDLE: begin
                if (r_pending) begin
                    w_start     = 1'b1;
                    w_takePend  = 1'b1;
                    w_startBank = r_pendBank;
                    w_nextState = ST_READ;
                end else if (swap_i) begin
                    w_start     = 1'b1;
                    w_startBank = r_wrBank;
                    w_nextState = ST_READ;
                end
            end
            ST_READ: begin
                if (w_issue && w_lastSlot) begin
                    if (r_pending) begin
                        w_start     = 1'b1;
                        w_takePend  = 1'b1;
                        w_startBank = r_pendBank;
                    end else begin
                        w_nextState = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (r_pending) begin
                    w_start     = 1'b1;
                    w_takePend  = 1'b1;
                    w_startBank = r_pendBank;
                    w_nextState = ST_READ;
                end else if (!r_inflight && (w_skidCount == 2'd0)) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Swaps are judged against the state before this edge: while busy (or
    // while a pending bank is being picked up from IDLE) the new bank becomes
    // the pending one, and replacing an existing pending bank is an overflow.
    assign w_swapToPend = swap_i && (w_busy || r_pending);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wrBank   <= '0;
            r_rdBank   <= '0;
            r_pendBank <= '0;
            r_pending  <= 1'b0;
            r_overflow <= 1'b0;
            r_slot     <= '0;
            r_inflight <= 1'b0;
            r_infSof   <= 1'b0;
            r_infEof   <= 1'b0;
        end else begin
            if (swap_i) begin
                r_wrBank <= r_wrBank + BBITS'(1);
            end
            if (w_start) begin
                r_rdBank <= w_startBank;
            end
            if (w_swapToPend) begin
                r_pending  <= 1'b1;
                r_pendBank <= r_wrBank;
            end else if (w_takePend) begin
                r_pending <= 1'b0;
            end
            if (swap_i && w_busy && r_pending) begin
                r_overflow <= 1'b1;
            end else if (clear_i) begin
                r_overflow <= 1'b0;
            end
            if (w_issue) begin
                r_slot <= w_lastSlot ? '0 : r_slot + SBITS'(1);
            end
            r_inflight <= w_issue;
            r_infSof   <= w_issue && (r_slot == '0);
            r_infEof   <= w_issue && w_lastSlot;
        end
    end

    tart_bank_readout_skid #(
        .W (SKW)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (r_inflight),
        .i_data  ({r_infSof, r_infEof, w_pushDat}),
        .i_ready (rdy_i),
        .o_valid (w_skidValid),
        .o_data  (w_skidOut),
        .o_count (w_skidCount)
    );

    assign stb_o      = w_skidValid;
    assign sof_o      = w_skidValid && w_skidOut[SKW-1];
    assign eof_o      = w_skidValid && w_skidOut[SKW-2];
    assign dat_o      = w_skidOut[WIDTH-1:0];
    assign bank_o     = r_rdBank;
    assign busy_o     = w_busy;
    assign overflow_o = r_overflow;

endmodule

// File: tb/tb_tart_bank_readout.sv
// -----------------------------------------------------------------------------
// tb_tart_bank_readout
// Self-checking bench for tart_bank_readout with WORDS=8, ABITS=3, BBITS=2.
// The RAM model returns {bank, addr} one cycle after each read strobe.
// Default build: cycle table for a single frame, then sequences for stalls,
// pending banks, overflow/clear and mid-frame reset.
// With TART_READOUT_HEADER_EN: two header-prefixed frames.
// -----------------------------------------------------------------------------
module tb_tart_bank_readout;

    localparam int WIDTH = 24;
    localparam int WORDS = 8;
    localparam int ABITS = 3;
    localparam int BBITS = 2;

    logic                   clk = 1'b0;
    logic                   rst_i = 1'b1;
    logic                   swap_i = 1'b0;
    logic                   clear_i = 1'b0;
    logic                   ram_rd_o;
    logic [BBITS+ABITS-1:0] ram_addr_o;
    logic [WIDTH-1:0]       ram_dat_i = '0;
    logic                   stb_o;
    logic                   rdy_i = 1'b1;
    logic [WIDTH-1:0]       dat_o;
    logic                   sof_o;
    logic                   eof_o;
    logic [BBITS-1:0]       bank_o;
    logic                   busy_o;
    logic                   overflow_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tart_bank_readout #(
        .WIDTH (WIDTH),
        .WORDS (WORDS),
        .ABITS (ABITS),
        .BBITS (BBITS)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .swap_i     (swap_i),
        .clear_i    (clear_i),
        .ram_rd_o   (ram_rd_o),
        .ram_addr_o (ram_addr_o),
        .ram_dat_i  (ram_dat_i),
        .stb_o      (stb_o),
        .rdy_i      (rdy_i),
        .dat_o      (dat_o),
        .sof_o      (sof_o),
        .eof_o      (eof_o),
        .bank_o     (bank_o),
        .busy_o     (busy_o),
        .overflow_o (overflow_o)
    );

    always @(posedge clk) begin
        if (ram_rd_o) ram_dat_i <= WIDTH'(ram_addr_o);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] dat;
        logic             sof;
        logic             eof;
        int               cyc;
    } word_t;

    word_t            got[$];
    logic             monEn = 1'b0;
    logic             prevStall = 1'b0;
    logic [WIDTH+1:0] prevOut = '0;
    int               cyc = 0;
    int               issued = 0;
    int               accepted = 0;
    int               maxOut = 0;

    always @(negedge clk) begin
        cyc++;
        if (monEn) begin
            if (prevStall) checkOutput("stall_hold", {stb_o, sof_o, eof_o, dat_o}, {1'b1, prevOut});
            prevStall = stb_o && !rdy_i;
            prevOut   = {sof_o, eof_o, dat_o};
            if (ram_rd_o) issued++;
            if (stb_o && rdy_i) begin
                accepted++;
                got.push_back('{dat_o, sof_o, eof_o, cyc});
            end
            if (issued - accepted > maxOut) maxOut = issued - accepted;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic sw, input logic rd, input logic clr);
        swap_i  = sw;
        rdy_i   = rd;
        clear_i = clr;
    endtask

    task automatic doReset();
        monEn = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0);
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic startMon();
        got.delete();
        prevStall = 1'b0;
        issued    = 0;
        accepted  = 0;
        maxOut    = 0;
        monEn     = 1'b1;
    endtask

    task automatic pulseSwap();
        swap_i = 1'b1;
        tick();
        swap_i = 1'b0;
    endtask

    task automatic waitWords(input int n, input int budget, input logic toggle, input string name);
        int k = 0;
        while (got.size() < n && k < budget) begin
            if (toggle) rdy_i = ~rdy_i;
            tick();
            k++;
        end
        checkOutput({name, "_count"}, got.size(), n);
    endtask

    task automatic waitIdle(input string name);
        int k = 0;
        while (busy_o && k < 40) begin
            tick();
            k++;
        end
        checkOutput({name, "_idle"}, busy_o, 0);
    endtask

    task automatic checkFrame(input int start, input int bank, input logic hdr, input string name);
        for (int i = 0; i < WORDS; i++) begin
            if (start + i < got.size()) begin
                word_t w;
                w = got[start + i];
                checkOutput($sformatf("%s_dat%0d", name, i), w.dat, (bank << ABITS) | i);
                checkOutput($sformatf("%s_sof%0d", name, i), w.sof, (!hdr && i == 0) ? 1 : 0);
                checkOutput($sformatf("%s_eof%0d", name, i), w.eof, (i == WORDS - 1) ? 1 : 0);
            end
        end
    endtask

`ifndef TART_READOUT_HEADER_EN
    typedef struct {
        logic             sw;
        logic             eStb;
        logic             eSof;
        logic             eEof;
        logic [WIDTH-1:0] eDat;
        logic             eBusy;
        logic             eRd;
        logic [4:0]       eAddr;
    } vec_t;

    function automatic vec_t mkVec(input logic sw, input logic stb, input logic sof, input logic eof,
                                   input int dat, input logic busy, input logic rd, input int addr);
        vec_t v;
        v.sw    = sw;
        v.eStb  = stb;
        v.eSof  = sof;
        v.eEof  = eof;
        v.eDat  = WIDTH'(dat);
        v.eBusy = busy;
        v.eRd   = rd;
        v.eAddr = 5'(addr);
        return v;
    endfunction
`endif

    initial begin
`ifndef TART_READOUT_HEADER_EN
        vec_t tbl[12];
        tbl[0]  = mkVec(1, 0, 0, 0, 0, 1, 1, 0);
        tbl[1]  = mkVec(0, 0, 0, 0, 0, 1, 1, 1);
        tbl[2]  = mkVec(0, 1, 1, 0, 0, 1, 1, 2);
        tbl[3]  = mkVec(0, 1, 0, 0, 1, 1, 1, 3);
        tbl[4]  = mkVec(0, 1, 0, 0, 2, 1, 1, 4);
        tbl[5]  = mkVec(0, 1, 0, 0, 3, 1, 1, 5);
        tbl[6]  = mkVec(0, 1, 0, 0, 4, 1, 1, 6);
        tbl[7]  = mkVec(0, 1, 0, 0, 5, 1, 1, 7);
        tbl[8]  = mkVec(0, 1, 0, 0, 6, 1, 0, 0);
        tbl[9]  = mkVec(0, 1, 0, 1, 7, 1, 0, 0);
        tbl[10] = mkVec(0, 0, 0, 0, 0, 1, 0, 0);
        tbl[11] = mkVec(0, 0, 0, 0, 0, 0, 0, 0);
`endif

        doReset();
        checkOutput("rst_stb",  stb_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_ovf",  overflow_o, 0);
        checkOutput("rst_rd",   ram_rd_o, 0);
        checkOutput("rst_addr", ram_addr_o, 0);
        checkOutput("rst_dat",  dat_o, 0);
        checkOutput("rst_bank", bank_o, 0);
        checkOutput("rst_sofeof", {sof_o, eof_o}, 0);

`ifndef TART_READOUT_HEADER_EN
        // Single frame, rdy held high: cycle-exact table.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i].sw, 1'b1, 1'b0);
            tick();
            checkOutput($sformatf("t1_stb%0d", i),  stb_o,  tbl[i].eStb);
            checkOutput($sformatf("t1_busy%0d", i), busy_o, tbl[i].eBusy);
            checkOutput($sformatf("t1_rd%0d", i),   ram_rd_o, tbl[i].eRd);
            checkOutput($sformatf("t1_bank%0d", i), bank_o, 0);
            if (tbl[i].eRd) checkOutput($sformatf("t1_addr%0d", i), ram_addr_o, tbl[i].eAddr);
            if (tbl[i].eStb) begin
                checkOutput($sformatf("t1_dat%0d", i), dat_o, tbl[i].eDat);
                checkOutput($sformatf("t1_sof%0d", i), sof_o, tbl[i].eSof);
                checkOutput($sformatf("t1_eof%0d", i), eof_o, tbl[i].eEof);
            end
        end
        applyStimulus(1'b0, 1'b1, 1'b0);

        // Toggling ready: no loss, no duplicates, held data, bounded reads.
        doReset();
        startMon();
        pulseSwap();
        waitWords(8, 60, 1'b1, "t2");
        rdy_i = 1'b1;
        waitIdle("t2");
        checkOutput("t2_total_words", got.size(), 8);
        checkFrame(0, 0, 1'b0, "t2");
        checkOutput("t2_outstanding_le2", (maxOut <= 2) ? 1 : 0, 1);

        // Second swap mid-frame: bank 1 follows bank 0 without a gap.
        doReset();
        startMon();
        pulseSwap();
        tick();
        tick();
        tick();
        pulseSwap();
        waitWords(16, 60, 1'b0, "t3");
        waitIdle("t3");
        checkFrame(0, 0, 1'b0, "t3a");
        checkFrame(8, 1, 1'b0, "t3b");
        if (got.size() >= 16) checkOutput("t3_no_gap", got[15].cyc - got[0].cyc, 15);
        checkOutput("t3_ovf", overflow_o, 0);

        // Three swaps in one frame: bank 1 is discarded, bank 2 read next.
        doReset();
        startMon();
        pulseSwap();
        tick();
        pulseSwap();
        tick();
        pulseSwap();
        checkOutput("t4_ovf_set", overflow_o, 1);
        waitWords(16, 60, 1'b0, "t4");
        waitIdle("t4");
        checkFrame(0, 0, 1'b0, "t4a");
        checkFrame(8, 2, 1'b0, "t4b");
        checkOutput("t4_ovf_sticky", overflow_o, 1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick();
        clear_i = 1'b0;
        checkOutput("t4_ovf_clear", overflow_o, 0);

        // Overflow set wins over a simultaneous clear.
        doReset();
        pulseSwap();
        pulseSwap();
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t4_set_over_clear", overflow_o, 1);
        waitIdle("t4c");

        // Reset at word 4 aborts the frame; a new swap restarts bank 0.
        doReset();
        startMon();
        pulseSwap();
        begin
            int k = 0;
            while (!(stb_o && dat_o == WIDTH'(4)) && k < 20) begin
                tick();
                k++;
            end
            checkOutput("t5_reach_word4", (stb_o && dat_o == WIDTH'(4)) ? 1 : 0, 1);
        end
        monEn = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checkOutput("t5_stb_after_rst",  stb_o, 0);
        checkOutput("t5_busy_after_rst", busy_o, 0);
        checkOutput("t5_rd_after_rst",   ram_rd_o, 0);
        startMon();
        pulseSwap();
        checkOutput("t5_restart_rd",   ram_rd_o, 1);
        checkOutput("t5_restart_addr", ram_addr_o, 0);
        waitWords(8, 40, 1'b0, "t5");
        waitIdle("t5");
        checkFrame(0, 0, 1'b0, "t5");
`else
        // Header mode: two 9-word frames with headers 0x000000 and 0x000101.
        startMon();
        pulseSwap();
        checkOutput("t6_busy", busy_o, 1);
        checkOutput("t6_hdr_no_rd", ram_rd_o, 0);
        tick();
        checkOutput("t6_rd0", ram_rd_o, 1);
        checkOutput("t6_addr0", ram_addr_o, 0);
        waitWords(9, 40, 1'b0, "t6a");
        pulseSwap();
        waitWords(18, 40, 1'b0, "t6b");
        waitIdle("t6");
        if (got.size() >= 18) begin
            checkOutput("t6_hdr0_dat", got[0].dat, 32'h000000);
            checkOutput("t6_hdr0_sof", got[0].sof, 1);
            checkOutput("t6_hdr0_eof", got[0].eof, 0);
            checkOutput("t6_hdr1_dat", got[9].dat, 32'h000101);
            checkOutput("t6_hdr1_sof", got[9].sof, 1);
            checkOutput("t6_hdr1_eof", got[9].eof, 0);
        end
        checkFrame(1, 0, 1'b1, "t6a");
        checkFrame(10, 1, 1'b1, "t6b");
        checkOutput("t6_total_words", got.size(), 18);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
